// File: rtl/simd_pe_param.sv
// SIMD processing element: takes a four-command setup (LD, LD, INFO, STORE), then streams
// vector beats from shared memory, computes LANES element-wise results and writes them back.
module simd_pe_param #(
  parameter int LANES  = 5,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16,
  localparam int BUS_W  = LANES * ELEM_W,
  localparam int SIZE_W = $clog2(LANES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_payload,
  output logic              o_cmd_ack,
  output logic              o_cmd_err,
  output logic              o_rd_req,
  input  logic              i_rd_grant,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [BUS_W-1:0]  i_rd_data,
  output logic              o_wr_req,
  input  logic              i_wr_grant,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [BUS_W-1:0]  o_wr_data,
  output logic [SIZE_W-1:0] o_wr_size,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_finish,
  input  logic              i_finish_ack
);

  // state  | meaning
  // IDLE   | waiting for i_en
  // LD0    | waiting for LD of src0 address
  // LD1    | waiting for LD of src1 address
  // INFO   | waiting for INFO word (op, sat, count)
  // STORE  | waiting for STORE of dst address
  // RD0    | reading op0 beat
  // RD1    | reading op1 beat
  // WR     | writing result beat
  // DONE   | finished, waiting for i_finish_ack
  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_INFO, S_STORE, S_RD0, S_RD1, S_WR, S_DONE
  } state_t;

  localparam int CNT_W = ADDR_W - 4;
  localparam logic [1:0] CMD_LD    = 2'd0;
  localparam logic [1:0] CMD_INFO  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_MAX = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [ELEM_W-1:0] MAX_V = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] MIN_V = {1'b1, {(ELEM_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic              cmd_hit, cmd_miss;
  logic [1:0]        exp_op;
  logic [BUS_W-1:0]  op0, op1, lanes_res;
  logic [ADDR_W-1:0] src0, src1, dst;
  logic [2:0]        alu_op;
  logic              sat;
  logic [CNT_W-1:0]  rem;
  logic              last_beat;
  logic [SIZE_W-1:0] size_raw;

  assign last_beat = (rem <= CNT_W'(LANES));
  assign size_raw  = (rem < CNT_W'(LANES)) ? rem[SIZE_W-1:0] : SIZE_W'(LANES);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_hit   = 1'b0;
    cmd_miss  = 1'b0;
    exp_op    = CMD_LD;
    case (state)
      S_INFO:  exp_op = CMD_INFO;
      S_STORE: exp_op = CMD_STORE;
      default: exp_op = CMD_LD;
    endcase
    case (state)
      S_IDLE: if (i_en) state_nxt = S_LD0;
      S_LD0, S_LD1, S_INFO, S_STORE: begin
        if (i_cmd_valid) begin
          if (i_cmd_op == exp_op) begin
            cmd_hit = 1'b1;
            case (state)
              S_LD0:   state_nxt = S_LD1;
              S_LD1:   state_nxt = S_INFO;
              S_INFO:  state_nxt = S_STORE;
              default: state_nxt = (rem == '0) ? S_DONE : S_RD0;
            endcase
          end else begin
            cmd_miss = 1'b1;
          end
        end
      end
      S_RD0: begin
        if (i_abort)         state_nxt = S_DONE;
        else if (i_rd_grant) state_nxt = S_RD1;
      end
      S_RD1: begin
        if (i_abort)         state_nxt = S_DONE;
        else if (i_rd_grant) state_nxt = S_WR;
      end
      S_WR: begin
        if (i_abort)         state_nxt = S_DONE;
        else if (i_wr_grant) state_nxt = last_beat ? S_DONE : S_RD0;
      end
      S_DONE: if (i_finish_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_req  = 1'b0;
    o_rd_addr = '0;
    o_wr_req  = 1'b0;
    o_wr_addr = '0;
    o_wr_size = '0;
    o_wr_data = '0;
    o_busy    = (state != S_IDLE);
    o_finish  = (state == S_DONE);
    case (state)
      S_RD0: begin
        o_rd_req  = 1'b1;
        o_rd_addr = src0;
      end
      S_RD1: begin
        o_rd_req  = 1'b1;
        o_rd_addr = src1;
      end
      S_WR: begin
        o_wr_req  = 1'b1;
        o_wr_addr = dst;
        o_wr_size = size_raw;
        o_wr_data = lanes_res;
      end
      default: ;
    endcase
  end

  // A beat cut short by abort must leave operands and counters untouched.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_cmd_ack <= 1'b0;
      o_cmd_err <= 1'b0;
      op0       <= '0;
      op1       <= '0;
      src0      <= '0;
      src1      <= '0;
      dst       <= '0;
      alu_op    <= '0;
      sat       <= 1'b0;
      rem       <= '0;
    end else begin
      o_cmd_ack <= cmd_hit;
      o_cmd_err <= cmd_miss;
      if (cmd_hit) begin
        case (state)
          S_LD0: src0 <= i_cmd_payload;
          S_LD1: src1 <= i_cmd_payload;
          S_INFO: begin
            alu_op <= i_cmd_payload[2:0];
            sat    <= i_cmd_payload[3];
            rem    <= i_cmd_payload[ADDR_W-1:4];
          end
          S_STORE: dst <= i_cmd_payload;
          default: ;
        endcase
      end
      if (!i_abort) begin
        if (state == S_RD0 && i_rd_grant) op0 <= i_rd_data;
        if (state == S_RD1 && i_rd_grant) op1 <= i_rd_data;
        if (state == S_WR && i_wr_grant && !last_beat) begin
          rem  <= rem - CNT_W'(LANES);
          src0 <= src0 + ADDR_W'(LANES);
          src1 <= src1 + ADDR_W'(LANES);
          dst  <= dst + ADDR_W'(LANES);
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [ELEM_W-1:0] a, b;
    logic signed [ELEM_W:0]   sum, dif;
    logic [ELEM_W-1:0]        res;

    assign a   = op0[l*ELEM_W +: ELEM_W];
    assign b   = op1[l*ELEM_W +: ELEM_W];
    assign sum = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
    assign dif = {a[ELEM_W-1], a} - {b[ELEM_W-1], b};

    // Overflow shows up as the two top bits of the widened result disagreeing.
    always_comb begin
      res = '0;
      case (alu_op)
        OP_ADD: res = (sat && (sum[ELEM_W] != sum[ELEM_W-1])) ?
                      (sum[ELEM_W] ? MIN_V : MAX_V) : sum[ELEM_W-1:0];
        OP_SUB: res = (sat && (dif[ELEM_W] != dif[ELEM_W-1])) ?
                      (dif[ELEM_W] ? MIN_V : MAX_V) : dif[ELEM_W-1:0];
        OP_MUL: res = a * b;
        OP_MAX: res = (a > b) ? a : b;
        OP_MIN: res = (a < b) ? a : b;
        default: res = '0;
      endcase
    end

    assign lanes_res[l*ELEM_W +: ELEM_W] = (int'(size_raw) > l) ? res : '0;
  end

endmodule

// File: tb/tb_simd_pe_param.sv
// Directed bench for simd_pe_param with default parameters (5 lanes x 16 bits).
module tb_simd_pe_param;

  localparam int LANES  = 5;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;
  localparam int BUS_W  = LANES * ELEM_W;
  localparam int SIZE_W = $clog2(LANES + 1);

  logic              i_clk = 1'b0;
  logic              i_rstn, i_en, i_cmd_valid;
  logic [1:0]        i_cmd_op;
  logic [ADDR_W-1:0] i_cmd_payload;
  logic              o_cmd_ack, o_cmd_err, o_rd_req, i_rd_grant;
  logic [ADDR_W-1:0] o_rd_addr, o_wr_addr;
  logic [BUS_W-1:0]  i_rd_data, o_wr_data;
  logic              o_wr_req, i_wr_grant, i_abort, o_busy, o_finish, i_finish_ack;
  logic [SIZE_W-1:0] o_wr_size;

  int checks = 0;
  int errors = 0;

  simd_pe_param #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en),
    .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op), .i_cmd_payload(i_cmd_payload),
    .o_cmd_ack(o_cmd_ack), .o_cmd_err(o_cmd_err),
    .o_rd_req(o_rd_req), .i_rd_grant(i_rd_grant), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_wr_req(o_wr_req), .i_wr_grant(i_wr_grant), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_wr_size(o_wr_size),
    .i_abort(i_abort), .o_busy(o_busy), .o_finish(o_finish), .i_finish_ack(i_finish_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] pk(input logic [15:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] pay, input string tag);
    i_cmd_valid = 1'b1;
    i_cmd_op = op;
    i_cmd_payload = pay;
    tick();
    i_cmd_valid = 1'b0;
    check({tag, "_ack"}, o_cmd_ack, 1'b1);
  endtask

  task automatic setup(input logic [15:0] s0, s1, info, d);
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    send_cmd(2'd0, s0, "ld0");
    send_cmd(2'd0, s1, "ld1");
    send_cmd(2'd1, info, "info");
    send_cmd(2'd2, d, "store");
  endtask

  // Entered with the DUT in RD0 and grants high; leaves it one cycle after WR.
  task automatic beat(input logic [15:0] s0, s1, d, input logic [BUS_W-1:0] a, b, exp,
                      input logic [SIZE_W-1:0] sz, input string tag);
    check({tag, "_rd0_req"}, o_rd_req, 1'b1);
    check({tag, "_rd0_addr"}, o_rd_addr, s0);
    i_rd_data = a;
    tick();
    check({tag, "_rd1_addr"}, o_rd_addr, s1);
    i_rd_data = b;
    tick();
    check({tag, "_wr_req"}, o_wr_req, 1'b1);
    check({tag, "_wr_addr"}, o_wr_addr, d);
    check({tag, "_wr_size"}, o_wr_size, sz);
    check({tag, "_wr_data"}, o_wr_data, exp);
    tick();
  endtask

  task automatic finish_seq(input string tag);
    check({tag, "_finish"}, o_finish, 1'b1);
    i_finish_ack = 1'b1;
    tick();
    i_finish_ack = 1'b0;
    check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  task automatic run_single(input logic [15:0] info, input logic [BUS_W-1:0] a, b, exp,
                            input string tag);
    setup(16'h0100, 16'h0200, info, 16'h0300);
    beat(16'h0100, 16'h0200, 16'h0300, a, b, exp, 3'd5, tag);
    finish_seq(tag);
  endtask

  initial begin
    i_rstn = 1'b0; i_en = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_payload = '0;
    i_rd_grant = 1'b1; i_wr_grant = 1'b1; i_rd_data = '0; i_abort = 1'b0; i_finish_ack = 1'b0;
    #2;
    check("rst_busy", o_busy, 1'b0);
    check("rst_rd_req", o_rd_req, 1'b0);
    check("rst_wr_req", o_wr_req, 1'b0);
    check("rst_wr_data", o_wr_data, '0);
    tick();
    tick();
    i_rstn = 1'b1;
    tick();

    // 12 elements of ADD: three beats, last one partial
    setup(16'h0010, 16'h0040, 16'h00C0, 16'h0080);
    beat(16'h0010, 16'h0040, 16'h0080, pk(1, 2, 3, 4, 5), pk(10, 20, 30, 40, 50),
         pk(11, 22, 33, 44, 55), 3'd5, "b0");
    beat(16'h0015, 16'h0045, 16'h0085, pk(100, 200, 300, 400, 500), pk(1, 1, 1, 1, 1),
         pk(101, 201, 301, 401, 501), 3'd5, "b1");
    beat(16'h001A, 16'h004A, 16'h008A, pk(7, 8, 9, 9, 9), pk(1, 1, 1, 1, 1),
         pk(8, 9, 0, 0, 0), 3'd2, "b2");
    check("t1_no_rd", o_rd_req, 1'b0);
    finish_seq("t1");

    // arithmetic, one full beat each
    run_single(16'h0058, pk(16'h7FF0, 16'h8000, 1, 0, 0), pk(16'h0020, 16'hFFFF, 1, 0, 0),
               pk(16'h7FFF, 16'h8000, 2, 0, 0), "add_sat");
    run_single(16'h0050, pk(16'h7FF0, 16'h8000, 1, 0, 0), pk(16'h0020, 16'hFFFF, 1, 0, 0),
               pk(16'h8010, 16'h7FFF, 2, 0, 0), "add_wrap");
    run_single(16'h0059, pk(16'h8000, 16'h7FFF, 5, 0, 0), pk(16'h0001, 16'hFFFF, 7, 0, 0),
               pk(16'h8000, 16'h7FFF, 16'hFFFE, 0, 0), "sub_sat");
    run_single(16'h0051, pk(16'h8000, 16'h7FFF, 5, 0, 0), pk(16'h0001, 16'hFFFF, 7, 0, 0),
               pk(16'h7FFF, 16'h8000, 16'hFFFE, 0, 0), "sub_wrap");
    run_single(16'h0053, pk(16'hFFFD, 16'h8000, 5, 1, 0), pk(16'h0002, 16'h7FFF, 5, 2, 0),
               pk(16'h0002, 16'h7FFF, 5, 2, 0), "max");
    run_single(16'h0054, pk(16'hFFFD, 16'h8000, 5, 1, 0), pk(16'h0002, 16'h7FFF, 5, 2, 0),
               pk(16'hFFFD, 16'h8000, 5, 1, 0), "min");
    run_single(16'h005A, pk(16'h0100, 16'hFFFF, 3, 0, 0), pk(16'h0100, 16'h0003, 5, 0, 0),
               pk(16'h0000, 16'hFFFD, 16'h000F, 0, 0), "mul");
    run_single(16'h0055, pk(1, 2, 3, 4, 5), pk(1, 2, 3, 4, 5), pk(0, 0, 0, 0, 0), "rsvd");

    // en with a command in IDLE, wrong opcode in LD0, then count=0
    i_en = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_op = 2'd0; i_cmd_payload = 16'h0011;
    tick();
    i_en = 1'b0;
    check("idle_cmd_busy", o_busy, 1'b1);
    check("idle_cmd_no_ack", o_cmd_ack, 1'b0);
    i_cmd_op = 2'd1;
    tick();
    i_cmd_valid = 1'b0;
    check("bad_op_err", o_cmd_err, 1'b1);
    check("bad_op_no_ack", o_cmd_ack, 1'b0);
    tick();
    check("err_one_cycle", o_cmd_err, 1'b0);
    send_cmd(2'd0, 16'h0011, "ld0_retry");
    check("retry_no_err", o_cmd_err, 1'b0);
    send_cmd(2'd0, 16'h0022, "ld1_z");
    send_cmd(2'd1, 16'h0000, "info_z");
    send_cmd(2'd2, 16'h0033, "store_z");
    check("zero_done", o_finish, 1'b1);
    check("zero_no_rd", o_rd_req, 1'b0);
    check("zero_no_wr", o_wr_req, 1'b0);
    finish_seq("zero");

    // read stall in RD1, then abort during WR with grant
    i_wr_grant = 1'b0;
    setup(16'h0010, 16'h0040, 16'h00C0, 16'h0080);
    i_rd_data = pk(1, 1, 1, 1, 1);
    tick();
    i_rd_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_req", o_rd_req, 1'b1);
      check("stall_addr", o_rd_addr, 16'h0040);
    end
    i_rd_grant = 1'b1;
    tick();
    check("stall_wr_req", o_wr_req, 1'b1);
    check("stall_wr_size", o_wr_size, 3'd5);
    i_wr_grant = 1'b1;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_done", o_finish, 1'b1);
    check("abort_no_wr", o_wr_req, 1'b0);
    tick();
    check("abort_no_rd", o_rd_req, 1'b0);
    check("abort_still_done", o_finish, 1'b1);
    finish_seq("abort");

    // reset while in WR, then a clean run
    setup(16'h0010, 16'h0040, 16'h0050, 16'h0080);
    i_rd_data = pk(3, 3, 3, 3, 3);
    tick();
    tick();
    check("pre_rst_wr", o_wr_req, 1'b1);
    i_rstn = 1'b0;
    #1;
    check("mid_rst_wr_req", o_wr_req, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_wr_addr", o_wr_addr, 16'h0000);
    check("mid_rst_wr_data", o_wr_data, '0);
    check("mid_rst_wr_size", o_wr_size, 3'd0);
    tick();
    i_rstn = 1'b1;
    tick();
    check("post_rst_idle", o_rd_req, 1'b0);
    run_single(16'h0050, pk(1, 2, 3, 4, 5), pk(5, 4, 3, 2, 1), pk(6, 6, 6, 6, 6), "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
